// File: rtl/ram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter: owner encoding, slot indices
// and the latched CPU access descriptor.
package ram_bus_arbiter_pkg;

  localparam int unsigned SLOT_LEN_DEF = 4;

  // Bus owner encoding (drives the address/data muxes)
  localparam logic [1:0] OWNER_NONE  = 2'd0;
  localparam logic [1:0] OWNER_CPU   = 2'd1;
  localparam logic [1:0] OWNER_VIDEO = 2'd2;
  localparam logic [1:0] OWNER_SPI   = 2'd3;

  // Slot index within the frame
  localparam logic [1:0] SLOT_VIDEO = 2'd0;
  localparam logic [1:0] SLOT_SPI   = 2'd1;
  localparam logic [1:0] SLOT_CPU   = 2'd2;

  // CPU access attributes captured once per CPU slot
  typedef struct packed {
    logic rw;
    logic enable;
    logic readonly;
    logic mirrored;
  } cpu_req_t;

endpackage

// File: rtl/ram_slot_timer.sv
// Frame counter for the shared SRAM bus. Decodes the *upcoming* cycle into
// slot index, in-slot offset and first/last flags so the arbiter can register
// its outputs aligned with the counter.
// Ports: clk, reset_n (async, active low); slot_c, offset_c, first_c, last_c
// describe the cycle the counter enters at the next clock edge.
module ram_slot_timer
  import ram_bus_arbiter_pkg::*;
#(
  parameter int unsigned SLOT_LEN = SLOT_LEN_DEF,
  localparam int unsigned OW = $clog2(2 * SLOT_LEN)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [1:0]    slot_c,
  output logic [OW-1:0] offset_c,
  output logic          first_c,
  output logic          last_c
);

  localparam int unsigned CW = OW + 1;
  localparam int unsigned SW = $clog2(SLOT_LEN);

  logic [CW-1:0] cycle;
  logic [CW-1:0] cycle_nxt;

  // Frame length is a power of two, so the counter wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycle <= '0;
    else          cycle <= cycle_nxt;
  end

  // MSB marks the CPU half of the frame; next bit down splits video/SPI
  always_comb begin
    cycle_nxt = cycle + CW'(1);
    slot_c    = SLOT_VIDEO;
    offset_c  = OW'(cycle_nxt[SW-1:0]);
    if (cycle_nxt[CW-1]) begin
      slot_c   = SLOT_CPU;
      offset_c = cycle_nxt[OW-1:0];
    end else if (cycle_nxt[CW-2]) begin
      slot_c = SLOT_SPI;
    end
    first_c = (offset_c == '0);
    last_c  = (slot_c == SLOT_CPU) ? (offset_c == OW'(2 * SLOT_LEN - 1))
                                   : (offset_c == OW'(SLOT_LEN - 1));
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Time-slices the shared SRAM bus between video fetch, the SPI host bridge
// and the 6502 CPU on a fixed frame (video, SPI, then a double-length CPU
// slot). Generates cpu_phi2 and the SRAM strobes; all outputs registered.
// Ports: clk, reset_n; CPU cpu_rw/cpu_halt plus decoder ram_enable,
// is_readonly, is_mirrored; video_req; spi_req/spi_rw. Outputs owner,
// ram_oe_n, ram_we_n, cpu_phi2 and 1-clk pulses cpu_data_strobe, video_ack,
// spi_ack, vram_write.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int unsigned SLOT_LEN = SLOT_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_rw,
  input  logic       cpu_halt,
  input  logic       ram_enable,
  input  logic       is_readonly,
  input  logic       is_mirrored,
  input  logic       video_req,
  input  logic       spi_req,
  input  logic       spi_rw,
  output logic [1:0] owner,
  output logic       ram_oe_n,
  output logic       ram_we_n,
  output logic       cpu_phi2,
  output logic       cpu_data_strobe,
  output logic       video_ack,
  output logic       spi_ack,
  output logic       vram_write
);

  localparam int unsigned OW = $clog2(2 * SLOT_LEN);

  logic [1:0]    slot_c;
  logic [OW-1:0] offset_c;
  logic          first_c;
  logic          last_c;

  ram_slot_timer #(.SLOT_LEN(SLOT_LEN)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .slot_c   (slot_c),
    .offset_c (offset_c),
    .first_c  (first_c),
    .last_c   (last_c)
  );

  logic       spi_rw_q;
  cpu_req_t   cpu_q;

  logic [1:0] owner_nxt;
  logic       oe_n_nxt;
  logic       we_n_nxt;
  logic       phi2_nxt;
  logic       strobe_nxt;
  logic       video_ack_nxt;
  logic       spi_ack_nxt;
  logic       vram_write_nxt;
  logic       spi_rw_nxt;
  cpu_req_t   cpu_nxt;
  cpu_req_t   cpu_cur;
  logic       cpu_wr_ok;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner           <= OWNER_NONE;
      ram_oe_n        <= 1'b1;
      ram_we_n        <= 1'b1;
      cpu_phi2        <= 1'b0;
      cpu_data_strobe <= 1'b0;
      video_ack       <= 1'b0;
      spi_ack         <= 1'b0;
      vram_write      <= 1'b0;
      spi_rw_q        <= 1'b0;
      cpu_q           <= '0;
    end else begin
      owner           <= owner_nxt;
      ram_oe_n        <= oe_n_nxt;
      ram_we_n        <= we_n_nxt;
      cpu_phi2        <= phi2_nxt;
      cpu_data_strobe <= strobe_nxt;
      video_ack       <= video_ack_nxt;
      spi_ack         <= spi_ack_nxt;
      vram_write      <= vram_write_nxt;
      spi_rw_q        <= spi_rw_nxt;
      cpu_q           <= cpu_nxt;
    end
  end

  // Slot arbitration and strobe generation for the upcoming cycle.
  // Strobes default high, so first/last offsets always turn the bus around.
  always_comb begin
    owner_nxt      = owner;
    oe_n_nxt       = 1'b1;
    we_n_nxt       = 1'b1;
    phi2_nxt       = 1'b0;
    strobe_nxt     = 1'b0;
    video_ack_nxt  = 1'b0;
    spi_ack_nxt    = 1'b0;
    vram_write_nxt = 1'b0;
    spi_rw_nxt     = spi_rw_q;
    cpu_nxt        = cpu_q;
    cpu_cur        = cpu_q;
    cpu_wr_ok      = 1'b0;

    case (slot_c)
      SLOT_VIDEO: begin
        if (first_c) begin
          owner_nxt = video_req ? OWNER_VIDEO : OWNER_NONE;
        end else if (owner == OWNER_VIDEO) begin
          if (last_c) video_ack_nxt = 1'b1;
          else        oe_n_nxt      = 1'b0;
        end
      end
      SLOT_SPI: begin
        if (first_c) begin
          owner_nxt  = spi_req ? OWNER_SPI : OWNER_NONE;
          spi_rw_nxt = spi_rw;
        end else if (owner == OWNER_SPI) begin
          if (last_c)        spi_ack_nxt = 1'b1;
          else if (spi_rw_q) oe_n_nxt    = 1'b0;
          else               we_n_nxt    = 1'b0;
        end
      end
      default: begin
        if (first_c) begin
          owner_nxt = cpu_halt ? OWNER_NONE : OWNER_CPU;
          phi2_nxt  = !cpu_halt;
        end else if (owner == OWNER_CPU) begin
          phi2_nxt = 1'b1;
          // Decoder outputs settle after phi2 rises; capture them at offset 1
          if (offset_c == OW'(1)) begin
            cpu_nxt.rw       = cpu_rw;
            cpu_nxt.enable   = ram_enable;
            cpu_nxt.readonly = is_readonly;
            cpu_nxt.mirrored = is_mirrored;
            cpu_cur          = cpu_nxt;
          end
          // ROM-mapped writes are dropped without any strobe
          cpu_wr_ok = !cpu_cur.rw && cpu_cur.enable && !cpu_cur.readonly;
          if (cpu_cur.rw && cpu_cur.enable && !last_c)
            oe_n_nxt = 1'b0;
          if (cpu_wr_ok && (offset_c >= OW'(SLOT_LEN)) && !last_c)
            we_n_nxt = 1'b0;
          if (offset_c == OW'(2 * SLOT_LEN - 2))
            strobe_nxt = 1'b1;
          if (last_c && cpu_wr_ok && cpu_cur.mirrored)
            vram_write_nxt = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
module tb_ram_bus_arbiter;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] C = 2'd1;
  localparam logic [1:0] V = 2'd2;
  localparam logic [1:0] P = 2'd3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_rw, cpu_halt, ram_enable, is_readonly, is_mirrored;
  logic       video_req, spi_req, spi_rw;
  logic [1:0] owner;
  logic       ram_oe_n, ram_we_n, cpu_phi2, cpu_data_strobe;
  logic       video_ack, spi_ack, vram_write;

  int checks = 0;
  int errors = 0;
  int cur_cyc = 0;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.SLOT_LEN(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cpu_rw          (cpu_rw),
    .cpu_halt        (cpu_halt),
    .ram_enable      (ram_enable),
    .is_readonly     (is_readonly),
    .is_mirrored     (is_mirrored),
    .video_req       (video_req),
    .spi_req         (spi_req),
    .spi_rw          (spi_rw),
    .owner           (owner),
    .ram_oe_n        (ram_oe_n),
    .ram_we_n        (ram_we_n),
    .cpu_phi2        (cpu_phi2),
    .cpu_data_strobe (cpu_data_strobe),
    .video_ack       (video_ack),
    .spi_ack         (spi_ack),
    .vram_write      (vram_write)
  );

  // One frame of held inputs plus expected per-cycle outputs (bit c = cycle c)
  typedef struct {
    logic        video_req, spi_req, spi_rw, cpu_rw, cpu_halt;
    logic        ram_enable, is_readonly, is_mirrored;
    logic [1:0]  own_v, own_s, own_c;
    logic [15:0] oe_n, we_n, phi2, ds, vack, sack, vw;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cur_cyc, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    video_req   = v.video_req;
    spi_req     = v.spi_req;
    spi_rw      = v.spi_rw;
    cpu_rw      = v.cpu_rw;
    cpu_halt    = v.cpu_halt;
    ram_enable  = v.ram_enable;
    is_readonly = v.is_readonly;
    is_mirrored = v.is_mirrored;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_owner"}, 16'(owner), 16'(N));
    chk({tag, "_oe_n"}, 16'(ram_oe_n), 16'd1);
    chk({tag, "_we_n"}, 16'(ram_we_n), 16'd1);
    chk({tag, "_phi2"}, 16'(cpu_phi2), 16'd0);
    chk({tag, "_pulses"},
        16'({cpu_data_strobe, video_ack, spi_ack, vram_write}), 16'd0);
  endtask

  // Advance into cycle c and compare every output against the vector
  task automatic run_cycle(input int c, input vec_t v);
    logic [1:0] eo;
    @(posedge clk);
    @(negedge clk);
    cur_cyc = c;
    eo = (c < 4) ? v.own_v : (c < 8) ? v.own_s : v.own_c;
    chk("owner", 16'(owner), 16'(eo));
    chk("ram_oe_n", 16'(ram_oe_n), 16'(v.oe_n[c]));
    chk("ram_we_n", 16'(ram_we_n), 16'(v.we_n[c]));
    chk("cpu_phi2", 16'(cpu_phi2), 16'(v.phi2[c]));
    chk("cpu_data_strobe", 16'(cpu_data_strobe), 16'(v.ds[c]));
    chk("video_ack", 16'(video_ack), 16'(v.vack[c]));
    chk("spi_ack", 16'(spi_ack), 16'(v.sack[c]));
    chk("vram_write", 16'(vram_write), 16'(v.vw[c]));
    chk("oe_we_both_low", 16'(!ram_oe_n && !ram_we_n), 16'd0);
    if (c == 0 || c == 3 || c == 4 || c == 7 || c == 8 || c == 15)
      chk("boundary_strobes", 16'({ram_oe_n, ram_we_n}), 16'd3);
  endtask

  // Called at a negedge with cycle 15 current; leaves the bench at cycle 15
  task automatic run_frame(input vec_t v);
    apply(v);
    for (int c = 0; c < 16; c++) run_cycle(c, v);
  endtask

  // Release reset (counter at 0) and run the partial first frame idle
  task automatic release_and_sync();
    apply(tbl[0]);
    reset_n = 1'b1;
    for (int c = 1; c < 16; c++) run_cycle(c, tbl[0]);
  endtask

  initial begin
    //            vreq  sreq  srw   crw   halt  en    ro    mir   ov sv cv oe_n      we_n      phi2      ds        vack      sack      vw
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, N, N, C, 16'hFFFF, 16'hFFFF, 16'hFF00, 16'h4000, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, N, N, C, 16'hFFFF, 16'h8FFF, 16'hFF00, 16'h4000, 16'h0000, 16'h0000, 16'h8000};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, N, N, C, 16'hFFFF, 16'hFFFF, 16'hFF00, 16'h4000, 16'h0000, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, V, N, C, 16'h81F9, 16'hFFFF, 16'hFF00, 16'h4000, 16'h0008, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, V, N, N, 16'hFFF9, 16'hFFFF, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 16'h0000};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, V, P, C, 16'h8199, 16'hFFFF, 16'hFF00, 16'h4000, 16'h0008, 16'h0080, 16'h0000};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, N, P, C, 16'hFFFF, 16'hFF9F, 16'hFF00, 16'h4000, 16'h0000, 16'h0080, 16'h0000};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, N, P, C, 16'hFFFF, 16'hFF9F, 16'hFF00, 16'h4000, 16'h0000, 16'h0080, 16'h0000};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, N, N, C, 16'hFFFF, 16'h8FFF, 16'hFF00, 16'h4000, 16'h0000, 16'h0000, 16'h0000};

    apply(tbl[0]);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    cur_cyc = 0;
    check_reset_state("reset");

    release_and_sync();

    for (int i = 0; i < 9; i++) run_frame(tbl[i]);

    // SPI write raised at cycle 5 waits a frame; dropped after its ack
    apply(tbl[0]);
    for (int c = 0; c < 6; c++) run_cycle(c, tbl[0]);
    spi_req = 1'b1;
    spi_rw  = 1'b0;
    for (int c = 6; c < 16; c++) run_cycle(c, tbl[0]);
    apply(tbl[6]);
    for (int c = 0; c < 8; c++) run_cycle(c, tbl[6]);
    spi_req = 1'b0;
    for (int c = 8; c < 16; c++) run_cycle(c, tbl[6]);
    run_frame(tbl[0]);

    // Asynchronous reset in the middle of an active CPU write strobe
    apply(tbl[1]);
    for (int c = 0; c < 14; c++) run_cycle(c, tbl[1]);
    #2 reset_n = 1'b0;
    #1 check_reset_state("async_reset");
    @(negedge clk);
    check_reset_state("held_reset");
    release_and_sync();
    run_frame(tbl[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Time-slices the single shared SRAM bus between the 6502 CPU, video fetch and the SPI host bridge on a fixed repeating frame. It generates the CPU phi2 clock and the SRAM strobes (ram_oe_n, ram_we_n).
- Sits downstream of the address decoder and consumes its ram_enable / is_readonly / is_mirrored outputs for the CPU address. This is what gates CPU writes to ROM-mapped space.

Parameters:
SLOT_LEN, 4, clocks per video/SPI slot; power of 2, >=4; CPU slot = 2*SLOT_LEN; frame = 4*SLOT_LEN (16 clk @16 MHz = 1 MHz CPU)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_rw  in  1  CPU R/W (1=read)
cpu_halt  in  1  1 = suppress CPU slot (phi2 held low)
ram_enable  in  1  from address decoder, CPU address hits RAM/VRAM/ROM
is_readonly  in  1  from address decoder, CPU address is ROM
is_mirrored  in  1  from address decoder, CPU address is VRAM
video_req  in  1  level; video fetch wants a read this frame
spi_req  in  1  level; SPI bridge wants an access
spi_rw  in  1  SPI direction (1=read), sampled with spi_req
owner  out  2  bus owner: 0=NONE 1=CPU 2=VIDEO 3=SPI (drives addr/data muxes)
ram_oe_n  out  1  SRAM output enable
ram_we_n  out  1  SRAM write enable
cpu_phi2  out  1  CPU phi2 clock
cpu_data_strobe  out  1  1-clk pulse; CPU read data valid / I/O access point
video_ack  out  1  1-clk pulse; video read data valid
spi_ack  out  1  1-clk pulse; SPI access complete (read data valid if read)
vram_write  out  1  1-clk pulse; CPU wrote a mirrored (VRAM) location

Behaviour:
- Reset: cycle=0, owner=NONE, ram_oe_n=1, ram_we_n=1, cpu_phi2=0, all pulses 0. All outputs are registered.
- Reset asserted mid-frame forces all of the above immediately (asynchronously). Any pending SPI/video request is dropped; the requester must re-request.
- Frame counter: cycle counts 0..4*SLOT_LEN-1 and wraps to 0. Let S=SLOT_LEN.
- Slot map:
  - Video slot: cycles 0..S-1.
  - SPI slot: cycles S..2S-1.
  - CPU slot: cycles 2S..4S-1.
- Slot entry: at its first clock a slot samples its request and sets owner; if no request, owner=NONE and the slot idles with no strobes.
  - video_req is sampled at cycle 0.
  - spi_req and spi_rw are sampled at cycle S and latched for the whole slot.
  - A request raised after its sample point waits for the next frame; no mid-slot grant.
- Video/SPI slot timing (offsets within the slot):
  - Offset 0: owner set.
  - Offsets 1..S-2 (reads): ram_oe_n=0.
  - Offsets 1..S-2 (SPI writes): ram_we_n=0.
  - Offset S-1: strobes high and ack pulse.
- SPI writes ignore is_readonly, so the host may load ROM images.
- SPI handshake: after spi_ack the bridge must drop spi_req before the next cycle S or a second access is performed. Back-to-back accesses are legal: one per frame.
- CPU slot:
  - cpu_phi2=1 for cycles 2S..4S-1, else 0. If cpu_halt is sampled 1 at cycle 2S, phi2 stays 0 for the whole slot and owner=NONE.
  - Offset 0 sets owner=CPU.
  - Read with ram_enable=1: ram_oe_n=0 on offsets 1..2S-2.
  - Write with ram_enable=1 and is_readonly=0: ram_we_n=0 on offsets S..2S-2.
  - Write with is_readonly=1: silently dropped, no strobe.
  - ram_enable=0 (I/O/magic): no SRAM strobes.
  - cpu_data_strobe pulses at offset 2S-2, one clock before phi2 falls.
  - vram_write pulses at offset 2S-1 for a completed write with is_mirrored=1.
- Decoder inputs and cpu_rw are sampled at offset 1 of the CPU slot and held for the slot.
- Invariant: ram_oe_n and ram_we_n are never simultaneously 0.
- Invariant: both are 1 on the first and last clock of every slot (bus turnaround).

Decomposition:
- Shared package holds:
  - Owner encoding constants OWNER_NONE/CPU/VIDEO/SPI.
  - Slot index constants SLOT_VIDEO=0, SLOT_SPI=1, SLOT_CPU=2.
- One natural sub-module, ram_slot_timer: the frame counter decoding cycle into slot index, offset, and first/last flags.
- Arbitration, strobe generation and acks stay in ram_bus_arbiter.

Test Plan:
- Reset release, no requests, cpu_halt=0 -> cpu_phi2 period 16 clk, high on cycles 8..15; ram_we_n=1 throughout; owner=CPU only on cycles 8..15.
- CPU write with ram_enable=1, is_readonly=0, is_mirrored=1 -> ram_we_n=0 on cycles 12..14; vram_write pulses at cycle 15. Repeat with is_readonly=1 -> ram_we_n stays 1, no vram_write.
- video_req=1 held -> every frame owner=VIDEO on cycles 0..3, ram_oe_n=0 on cycles 1..2, video_ack at cycle 3.
- SPI write request (spi_req=1, spi_rw=0) raised at cycle 5 -> no grant that frame; next frame owner=SPI on cycles 4..7, ram_we_n=0 on cycles 5..6, spi_ack at cycle 7.
- video_req, spi_req and a CPU read all active in one frame -> three slots in order VIDEO, SPI, CPU; oe_n/we_n never both low and high at every slot boundary.
- reset_n pulled low at cycle 10 during a CPU write -> ram_we_n=1, cpu_phi2=0, owner=NONE immediately; after release the frame restarts at cycle 0.
